// File: rtl/vga_pkg.sv
// Shared constants and colour helpers for the VGA pixel pipeline.
package vga_pkg;
  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int FB_W        = 160;
  localparam int FB_H        = 120;
  localparam int PIPE_LAT    = 3;
  localparam int VBLANK_LINE = 480;
  localparam int RGB332_W    = 8;
  localparam int RGB444_W    = 12;
  localparam int FB_ADDR_W   = 15;
  localparam int SPR_ADDR_W  = 8;
  localparam int COORD_W     = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Replicate MSBs so full-scale 332 maps to full-scale 444.
  function automatic rgb444_t expand332(input logic [RGB332_W-1:0] c);
    rgb444_t o;
    o.r = {c[7:5], c[7]};
    o.g = {c[4:2], c[4]};
    o.b = {c[1:0], c[1:0]};
    return o;
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line with a configurable reset value.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             ckVideo,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge ckVideo) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= RST_VAL;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/vga_pixel_pipe.sv
// Three-stage pixel pipeline: framebuffer fetch, sprite overlay, sync alignment.
module vga_pixel_pipe
  import vga_pkg::*;
#(
  parameter logic [RGB444_W-1:0] COLOR_KEY   = 12'hF0F,
  parameter int                  SPRITE_SIZE = 16
) (
  input  logic                  ckVideo,
  input  logic                  reset,
  input  logic [COORD_W-1:0]    adrHor,
  input  logic [COORD_W-1:0]    adrVer,
  input  logic                  flgActiveVideo,
  input  logic                  HS,
  input  logic                  VS,
  output logic [FB_ADDR_W-1:0]  fbAddr,
  input  logic [RGB332_W-1:0]   fbData,
  output logic [SPR_ADDR_W-1:0] spriteAddr,
  input  logic [RGB444_W-1:0]   spriteData,
  input  logic [COORD_W-1:0]    spriteX,
  input  logic [COORD_W-1:0]    spriteY,
  input  logic                  spriteEn,
  output logic [3:0]            vgaRed,
  output logic [3:0]            vgaGreen,
  output logic [3:0]            vgaBlue,
  output logic                  vgaHS,
  output logic                  vgaVS,
  output logic                  frameStart
);
  localparam int SB = $clog2(SPRITE_SIZE);

  logic [COORD_W-1:0] sX, sY;
  logic               sEn;
  logic               hit1, hit2;
  rgb444_t            raw3;
  logic               act3, hs3, vs3;

  // Stage 1 combinational: framebuffer address and sprite hit
  logic [FB_ADDR_W-1:0]  fb_v, fb_h, fb_lin;
  logic                  in_area, load_now;
  logic [COORD_W:0]      dx, dy;
  logic                  hit;
  logic [SPR_ADDR_W-1:0] spr_addr;

  always_comb begin
    fb_v     = FB_ADDR_W'(adrVer[COORD_W-1:2]);
    fb_h     = FB_ADDR_W'(adrHor[COORD_W-1:2]);
    fb_lin   = (fb_v << 7) + (fb_v << 5) + fb_h;
    in_area  = (adrHor < COORD_W'(H_ACTIVE)) && (adrVer < COORD_W'(V_ACTIVE));
    load_now = (adrHor == '0) && (adrVer == COORD_W'(VBLANK_LINE));
    // Widened differences are only meaningful once the >= guard holds.
    dx       = {1'b0, adrHor} - {1'b0, sX};
    dy       = {1'b0, adrVer} - {1'b0, sY};
    hit      = sEn
               && (adrHor >= sX) && (dx < (COORD_W+1)'(SPRITE_SIZE))
               && (adrVer >= sY) && (dy < (COORD_W+1)'(SPRITE_SIZE));
    spr_addr = hit ? {4'(dy[SB-1:0]), 4'(dx[SB-1:0])} : '0;
  end

  always_ff @(posedge ckVideo) begin
    if (reset) begin
      fbAddr     <= '0;
      spriteAddr <= '0;
      hit1       <= 1'b0;
      hit2       <= 1'b0;
      raw3       <= '0;
      sX         <= '0;
      sY         <= '0;
      sEn        <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      fbAddr     <= in_area ? fb_lin : '0;
      spriteAddr <= spr_addr;
      hit1       <= hit;
      hit2       <= hit1;
      // Sprite position only changes during vertical blank so a frame never tears.
      if (load_now) begin
        sX  <= spriteX;
        sY  <= spriteY;
        sEn <= spriteEn;
      end
      frameStart <= load_now;
      if (hit2 && spriteData != COLOR_KEY) raw3 <= spriteData;
      else                                 raw3 <= expand332(fbData);
    end
  end

  vga_delay_line #(
    .WIDTH  (3),
    .DEPTH  (PIPE_LAT),
    .RST_VAL(3'b011)
  ) u_sync (
    .ckVideo(ckVideo),
    .reset  (reset),
    .din    ({flgActiveVideo, HS, VS}),
    .dout   ({act3, hs3, vs3})
  );

  assign vgaRed   = act3 ? raw3.r : 4'h0;
  assign vgaGreen = act3 ? raw3.g : 4'h0;
  assign vgaBlue  = act3 ? raw3.b : 4'h0;
  assign vgaHS    = hs3;
  assign vgaVS    = vs3;
endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Randomized scoreboard bench for vga_pixel_pipe with a frame-level reference model.
module tb_vga_pixel_pipe;
  localparam logic [11:0] KEY = 12'hF0F;

  logic        ckVideo = 1'b0, reset = 1'b1;
  logic [9:0]  adrHor = '0, adrVer = '0, spriteX = '0, spriteY = '0;
  logic        flgActiveVideo = 1'b0, HS = 1'b1, VS = 1'b1, spriteEn = 1'b0;
  logic [7:0]  fbData = '0;
  logic [11:0] spriteData = '0;
  logic [14:0] fbAddr;
  logic [7:0]  spriteAddr;
  logic [3:0]  vgaRed, vgaGreen, vgaBlue;
  logic        vgaHS, vgaVS, frameStart;

  vga_pixel_pipe #(.COLOR_KEY(KEY), .SPRITE_SIZE(16)) dut (
    .ckVideo(ckVideo), .reset(reset), .adrHor(adrHor), .adrVer(adrVer),
    .flgActiveVideo(flgActiveVideo), .HS(HS), .VS(VS),
    .fbAddr(fbAddr), .fbData(fbData), .spriteAddr(spriteAddr), .spriteData(spriteData),
    .spriteX(spriteX), .spriteY(spriteY), .spriteEn(spriteEn),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .vgaHS(vgaHS), .vgaVS(vgaVS), .frameStart(frameStart)
  );

  always #5 ckVideo = ~ckVideo;

  // External synchronous memories: data one cycle after address.
  logic [7:0]  fbmem  [0:19199];
  logic [11:0] sprmem [0:255];
  always @(posedge ckVideo) begin
    fbData     <= fbmem[fbAddr];
    spriteData <= sprmem[spriteAddr];
  end

  typedef struct { int due; logic [11:0] rgb; logic hs; logic vs; } vexp_t;
  typedef struct { int due; logic [14:0] fa; logic [7:0] sa; logic fs; } aexp_t;
  vexp_t vq[$];
  aexp_t aq[$];

  int n_pass = 0, n_total = 0, cyc = 0;
  // Model state: sprite parameters as seen by the current frame, and pending inputs.
  int sh_x = 0, sh_y = 0, nx = 0, ny = 0;
  bit sh_en = 0, nen = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  function automatic logic [11:0] exp332(input logic [7:0] c);
    int r, g, b;
    r = c / 32; g = (c / 4) % 8; b = c % 4;
    return {4'(r * 2 + r / 4), 4'(g * 2 + g / 4), 4'(b * 5)};
  endfunction

  task automatic pix(input int h, input int v, input bit act,
                     input bit hs = 1, input bit vs = 1, input bit ck = 1);
    int fa, sa;
    bit hit;
    logic [11:0] col;
    @(negedge ckVideo);
    adrHor = 10'(h); adrVer = 10'(v); flgActiveVideo = act; HS = hs; VS = vs;
    spriteX = 10'(nx); spriteY = 10'(ny); spriteEn = nen;
    fa  = (h < 640 && v < 480) ? (v / 4) * 160 + h / 4 : 0;
    hit = sh_en && h >= sh_x && h < sh_x + 16 && v >= sh_y && v < sh_y + 16;
    sa  = hit ? (v - sh_y) * 16 + (h - sh_x) : 0;
    if (!act)                          col = '0;
    else if (hit && sprmem[sa] != KEY) col = sprmem[sa];
    else                               col = exp332(fbmem[fa]);
    if (ck) begin
      vq.push_back('{cyc + 3, col, hs, vs});
      aq.push_back('{cyc + 1, 15'(fa), 8'(sa), (h == 0 && v == 480)});
    end
    if (h == 0 && v == 480) begin
      sh_x = nx; sh_y = ny; sh_en = nen;
    end
  endtask

  // Monitor: compares every expectation that falls due on this edge.
  always begin
    @(posedge ckVideo);
    cyc++;
    #1;
    while (vq.size() > 0 && vq[0].due <= cyc) begin
      vexp_t e;
      e = vq.pop_front();
      chk("rgb", {20'h0, vgaRed, vgaGreen, vgaBlue}, {20'h0, e.rgb});
      chk("vgaHS", {31'h0, vgaHS}, {31'h0, e.hs});
      chk("vgaVS", {31'h0, vgaVS}, {31'h0, e.vs});
    end
    while (aq.size() > 0 && aq[0].due <= cyc) begin
      aexp_t e;
      e = aq.pop_front();
      chk("fbAddr", {17'h0, fbAddr}, {17'h0, e.fa});
      chk("spriteAddr", {24'h0, spriteAddr}, {24'h0, e.sa});
      chk("frameStart", {31'h0, frameStart}, {31'h0, e.fs});
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_rgb"}, {20'h0, vgaRed, vgaGreen, vgaBlue}, 32'h0);
    chk({tag, "_hs"}, {31'h0, vgaHS}, 32'h1);
    chk({tag, "_vs"}, {31'h0, vgaVS}, 32'h1);
    chk({tag, "_fs"}, {31'h0, frameStart}, 32'h0);
    chk({tag, "_fbAddr"}, {17'h0, fbAddr}, 32'h0);
    chk({tag, "_sprAddr"}, {24'h0, spriteAddr}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 19200; i++) fbmem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) sprmem[i] = ($urandom_range(0, 7) == 0) ? KEY : 12'($urandom);
    fbmem[321] = 8'hE3;
    sprmem[0]  = 12'h0A5;
    sprmem[17] = KEY;
    if (sprmem[255] == KEY) sprmem[255] = 12'h123;

    // Reset with live-looking inputs that would otherwise propagate.
    reset = 1'b1; adrHor = 10'd4; adrVer = 10'd8; flgActiveVideo = 1'b1; HS = 1'b0; VS = 1'b0;
    repeat (4) @(negedge ckVideo);
    check_reset_state("reset");
    reset = 1'b0;

    // Basic framebuffer path, sync delay, blanking, address bounds.
    pix(4, 8, 1);
    pix(100, 100, 1, 0, 1);
    pix(101, 100, 1, 1, 0);
    pix(102, 100, 0);
    pix(700, 10, 0);
    pix(639, 479, 1);
    pix(636, 476, 1);
    pix(0, 0, 1);

    // Sprite at (100,50).
    nx = 100; ny = 50; nen = 1;
    pix(0, 480, 0);
    pix(1, 480, 0);
    pix(100, 50, 1); pix(115, 65, 1); pix(116, 50, 1); pix(101, 51, 1);
    pix(99, 50, 1); pix(100, 66, 1);

    // Mid-frame move is deferred to the next frame.
    nx = 200;
    pix(5, 240, 1); pix(100, 50, 1); pix(200, 50, 1); pix(107, 60, 1);
    pix(0, 480, 0); pix(1, 480, 0);
    pix(200, 50, 1); pix(100, 50, 1); pix(215, 65, 1);

    // Right-edge clip.
    nx = 632; ny = 100;
    pix(0, 480, 0);
    for (int h = 628; h < 646; h++) pix(h, 100, h < 640);

    // Bottom-edge clip and origin placement.
    nx = 0; ny = 472;
    pix(0, 480, 0);
    for (int v = 470; v < 490; v++) pix(3, v, v < 480);
    nx = 0; ny = 0;
    pix(0, 480, 0);
    pix(0, 0, 1); pix(15, 15, 1); pix(16, 0, 1); pix(0, 16, 1);

    // Off-screen sprite origin.
    nx = 640; ny = 10;
    pix(0, 480, 0);
    pix(639, 10, 1); pix(700, 10, 0);

    // Mid-line reset: drain, stream, reset, then resume.
    nx = 300; ny = 200; nen = 1;
    pix(0, 480, 0);
    repeat (3) pix(0, 0, 0, 1, 1, 0);
    for (int h = 300; h < 305; h++) pix(h, 200, 1, 0, 0, 0);
    @(negedge ckVideo); reset = 1'b1;
    @(posedge ckVideo); #1;
    check_reset_state("midreset");
    @(negedge ckVideo); reset = 1'b0;
    sh_x = 0; sh_y = 0; sh_en = 0;
    pix(305, 200, 1); pix(306, 200, 1); pix(4, 8, 1);

    // Randomized traffic around and away from the sprite.
    for (int it = 0; it < 3000; it++) begin
      int h, v, r;
      bit act;
      r = int'($urandom_range(0, 299));
      if (r == 0) begin
        nx = int'($urandom_range(0, 660)); ny = int'($urandom_range(0, 490));
        nen = ($urandom_range(0, 9) != 0);
        pix(0, 480, 0);
        continue;
      end
      if (r < 8) nx = int'($urandom_range(0, 660));
      if ($urandom_range(0, 1) == 1) begin
        h = sh_x - 2 + int'($urandom_range(0, 19));
        v = sh_y - 2 + int'($urandom_range(0, 19));
      end else begin
        h = int'($urandom_range(0, 799));
        v = int'($urandom_range(0, 524));
      end
      if (h < 0) h = 0;
      if (v < 0) v = 0;
      if (h > 799) h = 799;
      if (v > 524) v = 524;
      act = (h < 640 && v < 480) && ($urandom_range(0, 15) != 0);
      pix(h, v, act, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
    end

    repeat (4) pix(0, 0, 0, 1, 1, 0);
    chk("drain", 32'(vq.size() + aq.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
